datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
REQ-001 Clock  input  1  single system clock; all state updates on rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset.
REQ-003 D_addr  input  8  data-memory address.
REQ-004 D_wr  input  1  data-memory write enable.
REQ-005 RF_s  input  1  RF write-data select: 1 = ALU result, 0 = data-memory read data.
REQ-006 RF_W_addr  input  4  register-file write address.
REQ-007 RF_W_en  input  1  register-file write enable.
REQ-008 RF_Ra_addr  input  4  register-file read port A address.
REQ-009 RF_Rb_addr  input  4  register-file read port B address.
REQ-010 ALU_s0  input  3  ALU operation select.
REQ-011 Ra_data  output  16  register-file port A read data.
REQ-012 Rb_data  output  16  register-file port B read data.
REQ-013 ALU_out  output  16  ALU result.
REQ-014 D_out  output  16  registered data-memory read data.
REQ-015 ALU_zero  output  1  high when ALU_out == 0.

Function
REQ-016 Register file SHALL be 16 x 16 bits, two combinational read ports (A, B), one synchronous write port.
REQ-017 RF write SHALL occur on the rising edge when RF_W_en=1: R[RF_W_addr] <= (RF_s ? ALU_out : D_out).
REQ-018 RF read of the address being written in the same cycle SHALL return the old value until the edge (no bypass).
REQ-019 Data memory SHALL be 256 x 16 bits, single port.
REQ-020 D_wr=1 SHALL write Ra_data to M[D_addr] on the rising edge.
REQ-021 D_out SHALL be registered: D_out <= M[D_addr] every edge, 1-cycle read latency.
REQ-022 Read-during-write to the same D_addr SHALL return the old contents on D_out.
REQ-023 The data-memory loop SHALL need two cycles: D_addr presented in cycle N, RF_s=0/RF_W_en=1 in cycle N+1 captures M[D_addr].
REQ-024 ALU SHALL be combinational, A = Ra_data, B = Rb_data, with ALU_s0 encodings:
  000 -> 0
  001 -> A+B
  010 -> A-B
  011 -> A
  100 -> A^B
  101 -> A|B
  110 -> A&B
  111 -> A+1
REQ-025 Arithmetic SHALL be unsigned modulo 2^16, carry/borrow discarded; no flags other than ALU_zero.
REQ-026 ALU_zero SHALL be combinational from ALU_out.
REQ-027 Simultaneous D_wr and RF_W_en SHALL both take effect in the same edge, using pre-edge values.

Reset
REQ-028 While Reset=1 at a rising edge, all 16 RF registers SHALL clear to 0x0000 and D_out to 0x0000.
REQ-029 Reset SHALL override RF_W_en and D_wr: no RF or memory write occurs on a reset edge.
REQ-030 Data-memory contents SHALL NOT be cleared by reset; they are undefined at power-up unless initialized by file.
REQ-031 After reset, Ra_data, Rb_data and ALU_out SHALL be 0 for any addresses; ALU_zero SHALL be 1 (except for op 111).

Structure
REQ-032 The shared package datapath_pkg SHALL hold the ALU opcode enum (3-bit), the data width (16), the RF address width (4) and the data-memory address width (8).
REQ-033 The register file SHALL be a separate sub-module named regfile; the ALU, write mux and data memory stay in datapath.
REQ-034 The data memory SHALL be coded to infer FPGA block RAM with a registered output.

Verification
REQ-035 Reset with all registers previously written -> every RF read returns 0x0000, D_out = 0x0000, ALU_zero = 1 for ALU_s0=000.
REQ-036 Write R1=0x0005 and R2=0xFFFE via D_out path; ALU_s0=001, Ra=1, Rb=2 -> ALU_out=0x0003 (wrap); ALU_s0=010 -> 0x0007.
REQ-037 R3=0x1234, D_wr=1, D_addr=0x20, Ra=3 -> next cycle D_addr=0x20 -> D_out=0x1234 one edge later; RF_s=0 writes R4=0x1234.
REQ-038 Same-edge write R5 (0xAAAA) while Ra=5 -> Ra_data shows old value before edge, 0xAAAA after.
REQ-039 Reset asserted with RF_W_en=1, D_wr=1 -> no write: M[D_addr] keeps prior value and the target register is 0.
REQ-040 Sweep all 8 ALU_s0 codes with A=0x00F0, B=0x0F0F -> 0000, 0FFF, F1E1, 00F0, 0FFF, 0FFF, 0000, 00F1; ALU_zero=1 only for codes 000 and 110.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared widths and ALU opcode encoding for the datapath slice.
package datapath_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned RF_AW  = 4;
  localparam int unsigned DM_AW  = 8;

  typedef enum logic [2:0] {
    ALU_ZERO   = 3'b000,
    ALU_ADD    = 3'b001,
    ALU_SUB    = 3'b010,
    ALU_PASS_A = 3'b011,
    ALU_XOR    = 3'b100,
    ALU_OR     = 3'b101,
    ALU_AND    = 3'b110,
    ALU_INC    = 3'b111
  } alu_op_e;

endpackage

// File: rtl/regfile.sv
// 16 x 16 register file: two combinational read ports, one synchronous
// write port, synchronous clear. Reads never bypass a same-edge write.
module regfile
  import datapath_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [RF_AW-1:0]  w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [RF_AW-1:0]  ra_addr,
  input  logic [RF_AW-1:0]  rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data
);

  localparam int unsigned NREGS = 1 << RF_AW;

  logic [DATA_W-1:0] regs [NREGS];

  // Register storage: reset clears every entry and masks the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[w_addr] <= w_data;
    end
  end

  // Combinational read ports.
  always_comb begin
    ra_data = regs[ra_addr];
    rb_data = regs[rb_addr];
  end

endmodule

// File: rtl/datapath.sv
// Datapath: register file, combinational ALU, RF write-data mux and a
// 256 x 16 single-port data memory with a registered, read-first output.
module datapath
  import datapath_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DM_AW-1:0]  D_addr,
  input  logic              D_wr,
  input  logic              RF_s,
  input  logic [RF_AW-1:0]  RF_W_addr,
  input  logic              RF_W_en,
  input  logic [RF_AW-1:0]  RF_Ra_addr,
  input  logic [RF_AW-1:0]  RF_Rb_addr,
  input  logic [2:0]        ALU_s0,
  output logic [DATA_W-1:0] Ra_data,
  output logic [DATA_W-1:0] Rb_data,
  output logic [DATA_W-1:0] ALU_out,
  output logic [DATA_W-1:0] D_out,
  output logic              ALU_zero
);

  localparam int unsigned DM_DEPTH = 1 << DM_AW;

  logic [DATA_W-1:0] rf_w_data;
  logic [DATA_W-1:0] mem [DM_DEPTH];

  regfile u_regfile (
    .clk     (Clock),
    .rst     (Reset),
    .we      (RF_W_en),
    .w_addr  (RF_W_addr),
    .w_data  (rf_w_data),
    .ra_addr (RF_Ra_addr),
    .rb_addr (RF_Rb_addr),
    .ra_data (Ra_data),
    .rb_data (Rb_data)
  );

  // RF write-data select: ALU result or registered memory read data.
  always_comb begin
    rf_w_data = RF_s ? ALU_out : D_out;
  end

  // ALU: unsigned modulo-2^16 arithmetic, carries discarded.
  always_comb begin
    ALU_out = '0;
    unique case (alu_op_e'(ALU_s0))
      ALU_ZERO:   ALU_out = '0;
      ALU_ADD:    ALU_out = Ra_data + Rb_data;
      ALU_SUB:    ALU_out = Ra_data - Rb_data;
      ALU_PASS_A: ALU_out = Ra_data;
      ALU_XOR:    ALU_out = Ra_data ^ Rb_data;
      ALU_OR:     ALU_out = Ra_data | Rb_data;
      ALU_AND:    ALU_out = Ra_data & Rb_data;
      ALU_INC:    ALU_out = Ra_data + DATA_W'(1);
      default:    ALU_out = '0;
    endcase
  end

  // Zero flag derived directly from the ALU result.
  always_comb begin
    ALU_zero = (ALU_out == '0);
  end

  // Memory array write; contents survive reset, reset only gates the write.
  always_ff @(posedge Clock) begin
    if (D_wr && !Reset) begin
      mem[D_addr] <= Ra_data;
    end
  end

  // Registered read port; read-first, so a same-address write shows old data.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      D_out <= '0;
    end else begin
      D_out <= mem[D_addr];
    end
  end

endmodule

// File: tb/tb_datapath.sv
// Directed self-checking bench for datapath.
module tb_datapath;
  import datapath_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [7:0]  D_addr;
  logic        D_wr;
  logic        RF_s;
  logic [3:0]  RF_W_addr;
  logic        RF_W_en;
  logic [3:0]  RF_Ra_addr;
  logic [3:0]  RF_Rb_addr;
  logic [2:0]  ALU_s0;
  logic [15:0] Ra_data;
  logic [15:0] Rb_data;
  logic [15:0] ALU_out;
  logic [15:0] D_out;
  logic        ALU_zero;

  int checks = 0;
  int errors = 0;

  datapath dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .D_addr     (D_addr),
    .D_wr       (D_wr),
    .RF_s       (RF_s),
    .RF_W_addr  (RF_W_addr),
    .RF_W_en    (RF_W_en),
    .RF_Ra_addr (RF_Ra_addr),
    .RF_Rb_addr (RF_Rb_addr),
    .ALU_s0     (ALU_s0),
    .Ra_data    (Ra_data),
    .Rb_data    (Rb_data),
    .ALU_out    (ALU_out),
    .D_out      (D_out),
    .ALU_zero   (ALU_zero)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Write R[dst] from the ALU.
  task automatic rf_alu(input logic [3:0] dst, input alu_op_e op,
                        input logic [3:0] ra, input logic [3:0] rb);
    RF_s = 1'b1; RF_W_en = 1'b1; RF_W_addr = dst;
    RF_Ra_addr = ra; RF_Rb_addr = rb; ALU_s0 = op;
    tick();
    RF_W_en = 1'b0;
  endtask

  // Build an arbitrary constant in R[dst] by double-and-increment.
  task automatic load_const(input logic [3:0] dst, input logic [15:0] val);
    rf_alu(dst, ALU_ZERO, 4'd0, 4'd0);
    for (int i = 15; i >= 0; i--) begin
      rf_alu(dst, ALU_ADD, dst, dst);
      if (val[i]) rf_alu(dst, ALU_INC, dst, 4'd0);
    end
  endtask

  task automatic store(input logic [7:0] addr, input logic [3:0] ra);
    D_addr = addr; RF_Ra_addr = ra; D_wr = 1'b1;
    tick();
    D_wr = 1'b0;
  endtask

  // Two-cycle memory load into R[dst].
  task automatic load(input logic [3:0] dst, input logic [7:0] addr);
    D_addr = addr;
    tick();
    RF_s = 1'b0; RF_W_en = 1'b1; RF_W_addr = dst;
    tick();
    RF_W_en = 1'b0;
  endtask

  logic [15:0] sweep_exp [8];
  logic        sweep_zero [8];

  initial begin
    sweep_exp = '{16'h0000, 16'h0FFF, 16'hF1E1, 16'h00F0,
                  16'h0FFF, 16'h0FFF, 16'h0000, 16'h00F1};
    sweep_zero = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    Reset = 1'b1; D_addr = '0; D_wr = 1'b0; RF_s = 1'b0; RF_W_addr = '0;
    RF_W_en = 1'b0; RF_Ra_addr = '0; RF_Rb_addr = '0; ALU_s0 = '0;
    tick(); tick();
    Reset = 1'b0;
    RF_Ra_addr = 4'd3; RF_Rb_addr = 4'd12; ALU_s0 = ALU_ZERO;
    #1;
    check("init_ra", Ra_data, 16'h0000);
    check("init_rb", Rb_data, 16'h0000);
    check("init_dout", D_out, 16'h0000);
    check("init_zero", {15'd0, ALU_zero}, 16'h0001);

    // Constants through the memory path, then add/sub wrap.
    load_const(4'd15, 16'h0005);
    store(8'h10, 4'd15);
    load(4'd1, 8'h10);
    load_const(4'd15, 16'hFFFE);
    store(8'h11, 4'd15);
    load(4'd2, 8'h11);
    RF_Ra_addr = 4'd1; RF_Rb_addr = 4'd2; ALU_s0 = ALU_ADD;
    #1;
    check("r1", Ra_data, 16'h0005);
    check("r2", Rb_data, 16'hFFFE);
    check("add_wrap", ALU_out, 16'h0003);
    check("add_zero", {15'd0, ALU_zero}, 16'h0000);
    ALU_s0 = ALU_SUB;
    #1;
    check("sub_wrap", ALU_out, 16'h0007);

    // Store/load round trip with read-during-write on D_out.
    load_const(4'd3, 16'h1234);
    store(8'h20, 4'd1);
    store(8'h20, 4'd3);
    check("rdw_old", D_out, 16'h0005);
    tick();
    check("mem_read", D_out, 16'h1234);
    RF_s = 1'b0; RF_W_en = 1'b1; RF_W_addr = 4'd4;
    tick();
    RF_W_en = 1'b0;
    RF_Ra_addr = 4'd4;
    #1;
    check("r4_load", Ra_data, 16'h1234);

    // Same-edge RF write/read: old value until the edge.
    load_const(4'd6, 16'hAAAA);
    store(8'h30, 4'd6);
    D_addr = 8'h30;
    tick();
    RF_s = 1'b0; RF_W_en = 1'b1; RF_W_addr = 4'd5; RF_Ra_addr = 4'd5;
    #1;
    check("r5_before", Ra_data, 16'h0000);
    tick();
    RF_W_en = 1'b0;
    check("r5_after", Ra_data, 16'hAAAA);

    // Simultaneous memory and RF write use pre-edge values.
    D_addr = 8'h40; D_wr = 1'b1;
    rf_alu(4'd1, ALU_INC, 4'd1, 4'd0);
    D_wr = 1'b0;
    RF_Ra_addr = 4'd1;
    #1;
    check("simul_rf", Ra_data, 16'h0006);
    load(4'd7, 8'h40);
    check("simul_mem", D_out, 16'h0005);
    RF_Ra_addr = 4'd7;
    #1;
    check("simul_r7", Ra_data, 16'h0005);

    // ALU sweep.
    load_const(4'd9, 16'h00F0);
    load_const(4'd10, 16'h0F0F);
    RF_Ra_addr = 4'd9; RF_Rb_addr = 4'd10;
    for (int i = 0; i < 8; i++) begin
      ALU_s0 = 3'(i);
      #1;
      check($sformatf("sweep_out_%0d", i), ALU_out, sweep_exp[i]);
      check($sformatf("sweep_zero_%0d", i), {15'd0, ALU_zero}, {15'd0, sweep_zero[i]});
    end

    // Populate every register, then reset with both write enables high.
    for (int i = 0; i < 16; i++) rf_alu(4'(i), ALU_INC, 4'(i), 4'd0);
    Reset = 1'b1; RF_s = 1'b1; RF_W_en = 1'b1; RF_W_addr = 4'd8;
    ALU_s0 = ALU_INC; RF_Ra_addr = 4'd1; D_addr = 8'h20; D_wr = 1'b1;
    tick();
    Reset = 1'b0; RF_W_en = 1'b0; D_wr = 1'b0;
    check("rst_dout", D_out, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      RF_Ra_addr = 4'(i); RF_Rb_addr = 4'(15 - i);
      #1;
      check($sformatf("rst_ra_%0d", i), Ra_data, 16'h0000);
      check($sformatf("rst_rb_%0d", i), Rb_data, 16'h0000);
    end
    ALU_s0 = ALU_ZERO;
    #1;
    check("rst_zero_op0", {15'd0, ALU_zero}, 16'h0001);
    ALU_s0 = ALU_INC;
    #1;
    check("rst_inc_out", ALU_out, 16'h0001);
    check("rst_inc_zero", {15'd0, ALU_zero}, 16'h0000);
    D_addr = 8'h20;
    tick();
    check("rst_mem_kept", D_out, 16'h1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
